// File: rtl/mcu_command_decoder.sv
// mcu_command_decoder
// Parses the mcu_bus byte stream (command/data tagged) into frame-buffer
// pixel write requests: NOP, SET_ADDR, WRITE, FILL. Reports sticky protocol
// errors and counts completed commands.
//
// Ports:
//   clock            system clock, rising edge
//   reset            asynchronous, active-low
//   byte_valid       one-cycle strobe, a bus byte is present
//   byte_is_command  1 = command byte, 0 = data byte
//   byte_data        bus byte
//   write_valid      pixel write request pending
//   write_ready      memory accepts request when valid && ready
//   write_address    pixel address
//   write_data       pixel value
//   busy             not IDLE, or a write is pending
//   error_unknown    sticky: undefined command received
//   error_overflow   sticky: data byte dropped while a write was stalled
//   command_count    completed commands, wraps at 256
module mcu_command_decoder #(
    parameter int ADDRESS_WIDTH = 22,
    parameter int COUNT_WIDTH   = 24
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     byte_valid,
    input  logic                     byte_is_command,
    input  logic [7:0]               byte_data,
    output logic                     write_valid,
    input  logic                     write_ready,
    output logic [ADDRESS_WIDTH-1:0] write_address,
    output logic [7:0]               write_data,
    output logic                     busy,
    output logic                     error_unknown,
    output logic                     error_overflow,
    output logic [7:0]               command_count
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ADDR      = 3'd1;
    localparam logic [2:0] ST_WRITE     = 3'd2;
    localparam logic [2:0] ST_FILL_ARGS = 3'd3;
    localparam logic [2:0] ST_FILL_RUN  = 3'd4;

    logic [2:0]               state_q,     state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q,      addr_d;
    logic [15:0]              arg_q,       arg_d;
    logic [1:0]               arg_cnt_q,   arg_cnt_d;
    logic [7:0]               colour_q,    colour_d;
    logic [COUNT_WIDTH-1:0]   fill_cnt_q,  fill_cnt_d;
    logic                     wr_valid_q,  wr_valid_d;
    logic [ADDRESS_WIDTH-1:0] wr_addr_q,   wr_addr_d;
    logic [7:0]               wr_data_q,   wr_data_d;
    logic                     err_unk_q,   err_unk_d;
    logic                     err_ovf_q,   err_ovf_d;
    logic [7:0]               cmd_cnt_q,   cmd_cnt_d;

    logic        accept;
    logic        slot_free;
    logic        cmd_strobe;
    logic        data_strobe;
    logic [23:0] assembled;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        arg_d      = arg_q;
        arg_cnt_d  = arg_cnt_q;
        colour_d   = colour_q;
        fill_cnt_d = fill_cnt_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        err_unk_d  = err_unk_q;
        err_ovf_d  = err_ovf_q;
        cmd_cnt_d  = cmd_cnt_q;

        accept      = wr_valid_q && write_ready;
        // A new request may be loaded when nothing is pending or the
        // pending one is accepted on this same edge.
        slot_free   = !wr_valid_q || write_ready;
        cmd_strobe  = byte_valid && byte_is_command;
        data_strobe = byte_valid && !byte_is_command;
        // Multi-byte arguments arrive MSB first; shifting keeps the last three.
        assembled   = {arg_q, byte_data};

        if (accept) begin
            wr_valid_d = 1'b0;
        end

        if (cmd_strobe) begin
            arg_cnt_d = 2'd0;
            // Leaving WRITE via a command byte completes that WRITE.
            if (state_q == ST_WRITE) begin
                cmd_cnt_d = cmd_cnt_d + 8'd1;
            end
            case (byte_data)
                8'h00: begin
                    state_d   = ST_IDLE;
                    cmd_cnt_d = cmd_cnt_d + 8'd1;
                end
                8'h01:   state_d = ST_ADDR;
                8'h02:   state_d = ST_WRITE;
                8'h03:   state_d = ST_FILL_ARGS;
                default: begin
                    state_d   = ST_IDLE;
                    err_unk_d = 1'b1;
                end
            endcase
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (data_strobe) begin
                        arg_d     = assembled[15:0];
                        arg_cnt_d = arg_cnt_q + 2'd1;
                        if (arg_cnt_q == 2'd2) begin
                            addr_d    = ADDRESS_WIDTH'(assembled);
                            cmd_cnt_d = cmd_cnt_q + 8'd1;
                            state_d   = ST_IDLE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (data_strobe) begin
                        if (slot_free) begin
                            wr_valid_d = 1'b1;
                            wr_addr_d  = addr_q;
                            wr_data_d  = byte_data;
                            addr_d     = addr_q + ADDRESS_WIDTH'(1);
                        end else begin
                            err_ovf_d = 1'b1;
                        end
                    end
                end
                ST_FILL_ARGS: begin
                    if (data_strobe) begin
                        arg_cnt_d = arg_cnt_q + 2'd1;
                        if (arg_cnt_q == 2'd0) begin
                            colour_d = byte_data;
                        end else begin
                            arg_d = assembled[15:0];
                        end
                        if (arg_cnt_q == 2'd3) begin
                            fill_cnt_d = COUNT_WIDTH'(assembled);
                            state_d    = ST_FILL_RUN;
                        end
                    end
                end
                ST_FILL_RUN: begin
                    // With nothing left to issue, the command completes once
                    // the last request has been accepted.
                    if (fill_cnt_q == '0) begin
                        if (slot_free) begin
                            cmd_cnt_d = cmd_cnt_q + 8'd1;
                            state_d   = ST_IDLE;
                        end
                    end else if (slot_free) begin
                        wr_valid_d = 1'b1;
                        wr_addr_d  = addr_q;
                        wr_data_d  = colour_q;
                        addr_d     = addr_q + ADDRESS_WIDTH'(1);
                        fill_cnt_d = fill_cnt_q - COUNT_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            arg_q      <= '0;
            arg_cnt_q  <= '0;
            colour_q   <= '0;
            fill_cnt_q <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            err_unk_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
            cmd_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            arg_q      <= arg_d;
            arg_cnt_q  <= arg_cnt_d;
            colour_q   <= colour_d;
            fill_cnt_q <= fill_cnt_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            err_unk_q  <= err_unk_d;
            err_ovf_q  <= err_ovf_d;
            cmd_cnt_q  <= cmd_cnt_d;
        end
    end

    assign write_valid    = wr_valid_q;
    assign write_address  = wr_addr_q;
    assign write_data     = wr_data_q;
    assign busy           = (state_q != ST_IDLE) || wr_valid_q;
    assign error_unknown  = err_unk_q;
    assign error_overflow = err_ovf_q;
    assign command_count  = cmd_cnt_q;

endmodule

// File: tb/tb_mcu_command_decoder.sv
// Testbench for mcu_command_decoder: directed scenarios plus a randomized
// command stream checked against a protocol-level reference model.
module tb_mcu_command_decoder;

    localparam int AW = 22;

    logic          clock;
    logic          reset;
    logic          byte_valid;
    logic          byte_is_command;
    logic [7:0]    byte_data;
    logic          write_valid;
    logic          write_ready;
    logic [AW-1:0] write_address;
    logic [7:0]    write_data;
    logic          busy;
    logic          error_unknown;
    logic          error_overflow;
    logic [7:0]    command_count;

    logic ready_ctl;
    logic rand_ready;
    logic rand_ready_en;

    int n_cmp;
    int n_fail;

    logic [AW+7:0] obs_q[$];
    logic [AW+7:0] exp_q[$];

    // Reference model state
    int            m_mode;   // 0 idle, 1 collecting address, 2 write, 3 fill args
    logic [AW-1:0] m_addr;
    int            m_cnt;
    bit            m_unk;
    logic [7:0]    m_args[$];

    assign write_ready = rand_ready_en ? rand_ready : ready_ctl;

    mcu_command_decoder #(.ADDRESS_WIDTH(AW), .COUNT_WIDTH(24)) dut (
        .clock           (clock),
        .reset           (reset),
        .byte_valid      (byte_valid),
        .byte_is_command (byte_is_command),
        .byte_data       (byte_data),
        .write_valid     (write_valid),
        .write_ready     (write_ready),
        .write_address   (write_address),
        .write_data      (write_data),
        .busy            (busy),
        .error_unknown   (error_unknown),
        .error_overflow  (error_overflow),
        .command_count   (command_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change only at #1 after posedge, so valid && ready seen at the
    // falling edge is exactly what the next rising edge accepts.
    always @(negedge clock) begin
        if (reset && write_valid && write_ready) obs_q.push_back({write_address, write_data});
    end

    always @(posedge clock) begin
        #1;
        rand_ready = ($urandom_range(0, 9) < 7);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send(input bit is_cmd, input logic [7:0] b);
        byte_valid      = 1'b1;
        byte_is_command = is_cmd;
        byte_data       = b;
        @(posedge clock);
        #1;
        byte_valid      = 1'b0;
        byte_is_command = 1'b0;
    endtask

    task automatic do_reset();
        reset         = 1'b0;
        byte_valid    = 1'b0;
        byte_is_command = 1'b0;
        byte_data     = 8'h00;
        ready_ctl     = 1'b1;
        rand_ready_en = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        obs_q.delete();
    endtask

    // ---------------- reference model ----------------
    task automatic m_command(input logic [7:0] b);
        m_args.delete();
        if (m_mode == 2) m_cnt++;
        case (b)
            8'h00: begin m_cnt++; m_mode = 0; end
            8'h01: m_mode = 1;
            8'h02: m_mode = 2;
            8'h03: m_mode = 3;
            default: begin m_unk = 1'b1; m_mode = 0; end
        endcase
    endtask

    task automatic m_databyte(input logic [7:0] b);
        logic [23:0] full;
        int n;
        if (m_mode == 1) begin
            m_args.push_back(b);
            if (m_args.size() == 3) begin
                full   = {m_args[0], m_args[1], m_args[2]};
                m_addr = full[AW-1:0];
                m_cnt++;
                m_mode = 0;
            end
        end else if (m_mode == 2) begin
            exp_q.push_back({m_addr, b});
            m_addr = m_addr + 1'b1;
        end else if (m_mode == 3) begin
            m_args.push_back(b);
            if (m_args.size() == 4) begin
                n = int'({m_args[1], m_args[2], m_args[3]});
                for (int i = 0; i < n; i++) begin
                    exp_q.push_back({m_addr, m_args[0]});
                    m_addr = m_addr + 1'b1;
                end
                m_cnt++;
                m_mode = 0;
            end
        end
    endtask

    task automatic sb(input bit is_cmd, input logic [7:0] b);
        if (is_cmd) m_command(b);
        else        m_databyte(b);
        send(is_cmd, b);
    endtask

    task automatic wait_no_write();
        int t = 0;
        while (write_valid && t < 300) begin tick(1); t++; end
        if (write_valid) begin
            n_cmp++; n_fail++;
            $display("FAIL rnd_wait_valid: write_valid still %b after %0d cycles, want 0", write_valid, t);
        end
    endtask

    task automatic wait_not_busy();
        int t = 0;
        while (busy && t < 300) begin tick(1); t++; end
        if (busy) begin
            n_cmp++; n_fail++;
            $display("FAIL rnd_wait_busy: busy still %b after %0d cycles, want 0", busy, t);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b0;
        byte_valid = 1'b0; byte_is_command = 1'b0; byte_data = 8'h00;
        ready_ctl = 1'b1; rand_ready_en = 1'b0;
        #1;
        n_cmp++;
        if ({write_valid, write_address, write_data, busy, error_unknown, error_overflow, command_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b addr=%h data=%h busy=%b eu=%b eo=%b cnt=%0d, want all 0",
                     write_valid, write_address, write_data, busy, error_unknown, error_overflow, command_count);
        end
        do_reset();
    endtask

    task automatic test_write_basic();
        do_reset();
        send(1, 8'h01); send(0, 8'h00); send(0, 8'h00); send(0, 8'h10);
        n_cmp++;
        if (command_count !== 8'd1) begin n_fail++; $display("FAIL wb_cnt_setaddr: got %0d want 1", command_count); end
        send(1, 8'h02);
        send(0, 8'hAA);
        n_cmp++;
        if ({write_valid, write_address, write_data} !== {1'b1, 22'h000010, 8'hAA}) begin
            n_fail++; $display("FAIL wb_first: valid=%b addr=%h data=%h want 1/000010/aa", write_valid, write_address, write_data);
        end
        send(0, 8'hBB);
        n_cmp++;
        if ({write_valid, write_address, write_data} !== {1'b1, 22'h000011, 8'hBB}) begin
            n_fail++; $display("FAIL wb_second: valid=%b addr=%h data=%h want 1/000011/bb", write_valid, write_address, write_data);
        end
        tick(1);
        n_cmp++;
        if (write_valid !== 1'b0 || command_count !== 8'd1) begin
            n_fail++; $display("FAIL wb_after: valid=%b cnt=%0d want 0/1", write_valid, command_count);
        end
        send(1, 8'h01);
        n_cmp++;
        if (command_count !== 8'd2) begin n_fail++; $display("FAIL wb_cnt_exit: got %0d want 2", command_count); end
        n_cmp++;
        if (obs_q.size() != 2 || obs_q[0] !== {22'h000010, 8'hAA} || obs_q[1] !== {22'h000011, 8'hBB}) begin
            n_fail++; $display("FAIL wb_accepted: %0d writes accepted, want 2 (10/aa, 11/bb)", obs_q.size());
        end
    endtask

    task automatic test_fill_wrap();
        logic [AW-1:0] want_a[3];
        want_a[0] = 22'h3FFFFF; want_a[1] = 22'h000000; want_a[2] = 22'h000001;
        do_reset();
        send(1, 8'h01); send(0, 8'hFF); send(0, 8'hFF); send(0, 8'hFF);
        send(1, 8'h03); send(0, 8'h55); send(0, 8'h00); send(0, 8'h00); send(0, 8'h03);
        n_cmp++;
        if (write_valid !== 1'b0) begin n_fail++; $display("FAIL fill_pre: valid=%b want 0", write_valid); end
        for (int i = 0; i < 3; i++) begin
            tick(1);
            n_cmp++;
            if ({write_valid, write_address, write_data} !== {1'b1, want_a[i], 8'h55}) begin
                n_fail++; $display("FAIL fill_beat%0d: valid=%b addr=%h data=%h want 1/%h/55",
                                   i, write_valid, write_address, write_data, want_a[i]);
            end
        end
        tick(1);
        n_cmp++;
        if (write_valid !== 1'b0 || busy !== 1'b0 || command_count !== 8'd2) begin
            n_fail++; $display("FAIL fill_done: valid=%b busy=%b cnt=%0d want 0/0/2", write_valid, busy, command_count);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        ready_ctl = 1'b0;
        send(1, 8'h01); send(0, 8'h00); send(0, 8'h00); send(0, 8'h05);
        send(1, 8'h02);
        send(0, 8'h11);
        n_cmp++;
        if ({write_valid, write_address, write_data} !== {1'b1, 22'h000005, 8'h11}) begin
            n_fail++; $display("FAIL ovf_first: valid=%b addr=%h data=%h want 1/000005/11", write_valid, write_address, write_data);
        end
        send(0, 8'h22);
        n_cmp++;
        if ({write_valid, write_address, write_data, error_overflow} !== {1'b1, 22'h000005, 8'h11, 1'b1}) begin
            n_fail++; $display("FAIL ovf_drop: valid=%b addr=%h data=%h eo=%b want 1/000005/11/1",
                               write_valid, write_address, write_data, error_overflow);
        end
        tick(2);
        n_cmp++;
        if ({write_valid, write_address, write_data} !== {1'b1, 22'h000005, 8'h11}) begin
            n_fail++; $display("FAIL ovf_hold: valid=%b addr=%h data=%h want 1/000005/11", write_valid, write_address, write_data);
        end
        ready_ctl = 1'b1;
        tick(1);
        n_cmp++;
        if (write_valid !== 1'b0 || obs_q.size() != 1 || obs_q[0] !== {22'h000005, 8'h11}) begin
            n_fail++; $display("FAIL ovf_accept: valid=%b accepted=%0d want 0 and one write 000005/11", write_valid, obs_q.size());
        end
        send(0, 8'h33);
        n_cmp++;
        if ({write_address, write_data, error_overflow} !== {22'h000006, 8'h33, 1'b1}) begin
            n_fail++; $display("FAIL ovf_next: addr=%h data=%h eo=%b want 000006/33/1", write_address, write_data, error_overflow);
        end
    endtask

    task automatic test_unknown();
        do_reset();
        send(1, 8'h7E);
        n_cmp++;
        if ({error_unknown, command_count, write_valid, busy} !== {1'b1, 8'd0, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL unk_flag: eu=%b cnt=%0d valid=%b busy=%b want 1/0/0/0",
                               error_unknown, command_count, write_valid, busy);
        end
        send(1, 8'h00);
        n_cmp++;
        if (command_count !== 8'd1 || error_unknown !== 1'b1) begin
            n_fail++; $display("FAIL unk_nop: cnt=%0d eu=%b want 1/1", command_count, error_unknown);
        end
    endtask

    task automatic test_abort_addr();
        do_reset();
        send(1, 8'h01); send(0, 8'h00); send(0, 8'h00); send(0, 8'h20);
        send(1, 8'h01); send(0, 8'h12);
        send(1, 8'h02);
        n_cmp++;
        if (command_count !== 8'd1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL abort_cnt: cnt=%0d busy=%b want 1/1", command_count, busy);
        end
        send(0, 8'h44);
        n_cmp++;
        if ({write_valid, write_address, write_data} !== {1'b1, 22'h000020, 8'h44}) begin
            n_fail++; $display("FAIL abort_addr: valid=%b addr=%h data=%h want 1/000020/44", write_valid, write_address, write_data);
        end
    endtask

    task automatic test_reset_mid_fill();
        int t = 0;
        int n0;
        do_reset();
        send(1, 8'h01); send(0, 8'h00); send(0, 8'h00); send(0, 8'h00);
        send(1, 8'h03); send(0, 8'h77); send(0, 8'h00); send(0, 8'h01); send(0, 8'h00);
        while (obs_q.size() < 10 && t < 50) begin tick(1); t++; end
        n_cmp++;
        if (obs_q.size() < 10) begin n_fail++; $display("FAIL rmf_progress: %0d writes, want >= 10", obs_q.size()); end
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({write_valid, write_address, write_data, busy, error_unknown, error_overflow, command_count} !== '0) begin
            n_fail++; $display("FAIL rmf_async: valid=%b addr=%h data=%h busy=%b cnt=%0d want all 0",
                               write_valid, write_address, write_data, busy, command_count);
        end
        tick(2);
        reset = 1'b1;
        n0 = obs_q.size();
        tick(20);
        n_cmp++;
        if (obs_q.size() != n0 || write_valid !== 1'b0 || busy !== 1'b0 || command_count !== 8'd0) begin
            n_fail++; $display("FAIL rmf_quiet: new writes=%0d valid=%b busy=%b cnt=%0d want 0/0/0/0",
                               obs_q.size() - n0, write_valid, busy, command_count);
        end
    endtask

    task automatic test_random();
        int op;
        int k;
        do_reset();
        exp_q.delete();
        m_args.delete();
        m_mode = 0; m_addr = '0; m_cnt = 0; m_unk = 1'b0;
        rand_ready_en = 1'b1;
        for (int it = 0; it < 60; it++) begin
            op = $urandom_range(0, 9);
            case (op)
                0: sb(1, 8'h00);
                1, 2: begin
                    sb(1, 8'h01);
                    k = $urandom_range(1, 3);
                    if (k == 3 && $urandom_range(0, 2) == 0) begin
                        sb(0, 8'h00); sb(0, 8'h3F); sb(0, 8'hFE);
                    end else begin
                        for (int j = 0; j < k; j++) sb(0, 8'($urandom_range(0, 255)));
                    end
                end
                3, 4: begin
                    sb(1, 8'h02);
                    k = $urandom_range(1, 4);
                    for (int j = 0; j < k; j++) begin
                        wait_no_write();
                        sb(0, 8'($urandom_range(0, 255)));
                    end
                end
                5, 6: begin
                    sb(1, 8'h03);
                    sb(0, 8'($urandom_range(0, 255)));
                    sb(0, 8'h00); sb(0, 8'h00);
                    sb(0, 8'($urandom_range(0, 5)));
                    wait_not_busy();
                end
                7: sb(1, 8'($urandom_range(4, 255)));
                8: begin
                    if (m_mode == 0) sb(0, 8'($urandom_range(0, 255)));
                    else             sb(1, 8'h00);
                end
                default: begin
                    sb(1, 8'h03);
                    k = $urandom_range(1, 3);
                    for (int j = 0; j < k; j++) sb(0, 8'($urandom_range(0, 255)));
                end
            endcase
        end
        sb(1, 8'h00);
        wait_not_busy();
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rnd_write_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL rnd_write%0d: got addr=%h data=%h want addr=%h data=%h",
                                   i, obs_q[i][AW+7:8], obs_q[i][7:0], exp_q[i][AW+7:8], exp_q[i][7:0]);
            end
        end
        n_cmp++;
        if (command_count !== 8'(m_cnt)) begin
            n_fail++; $display("FAIL rnd_count: got %0d want %0d", command_count, 8'(m_cnt));
        end
        n_cmp++;
        if (error_unknown !== m_unk || error_overflow !== 1'b0) begin
            n_fail++; $display("FAIL rnd_errors: eu=%b eo=%b want %b/0", error_unknown, error_overflow, m_unk);
        end
        rand_ready_en = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_write_basic();
        test_fill_wrap();
        test_overflow();
        test_unknown();
        test_abort_addr();
        test_reset_mid_fill();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mcu_command_decoder.md
Name: mcu_command_decoder

Overview:
- Sits directly downstream of mcu_bus in msgpu, in the system clock domain.
- Consumes the byte stream mcu_bus produces, tagged command or data, and parses the frame-buffer protocol: set address, write pixels, fill, nop.
- Emits one-pixel write requests (address + pixel byte) toward frame-buffer memory over a valid/ready handshake.
- Reports sticky protocol errors and the number of completed commands.

Parameters:
ADDRESS_WIDTH, 22, frame-buffer address width; matches the VGA read_address width
COUNT_WIDTH, 24, fill-count width

Ports:
clock  input  1  system clock; every register is rising-edge
reset  input  1  asynchronous, active-low; asserted when 0
byte_valid  input  1  one-cycle strobe: a new bus byte is present
byte_is_command  input  1  qualifies byte_valid; 1 = command byte, 0 = data byte
byte_data  input  8  byte from mcu_bus
write_valid  output  1  pixel write request pending
write_ready  input  1  memory accepts the request when write_valid && write_ready on a rising edge
write_address  output  ADDRESS_WIDTH  pixel address
write_data  output  8  pixel value
busy  output  1  1 in any state other than IDLE, or while write_valid is 1
error_unknown  output  1  sticky: an undefined command byte was received
error_overflow  output  1  sticky: a data byte was dropped because a write was still pending
command_count  output  8  number of completed commands, wraps 255->0

Behaviour:
- Reset (reset==0, async):
  - state=IDLE; address register=0; write_valid=0; write_address=0; write_data=0.
  - error_unknown=0; error_overflow=0; command_count=0; busy=0.
  - Reset mid-command discards all progress. No write is issued after release until a new command arrives.
- Command codes:
  - 0x00 NOP: command_count+1, stay IDLE.
  - 0x01 SET_ADDR: go to ADDR and collect 3 data bytes, MSB first. Address = {b0,b1,b2}[ADDRESS_WIDTH-1:0]; upper bits are ignored.
  - 0x02 WRITE: go to WRITE; each data byte becomes one pixel write.
  - 0x03 FILL: go to FILL_ARGS and collect 4 data bytes: colour, then count MSB first. Then go to FILL_RUN.
  - Any other value: set error_unknown, go to IDLE, count unchanged.
- Command-byte priority: a command byte in any state aborts the current command and is decoded immediately as above.
  - The aborted command does not increment command_count.
  - A pending write_valid is not withdrawn; it completes normally.
- Data bytes in IDLE are ignored silently; no error.
- ADDR state:
  - After the 3rd byte: load the address register, command_count+1, return to IDLE.
  - Fewer than 3 bytes followed by a command byte: the address is unchanged.
- WRITE state:
  - Data byte with write_valid==0, or with write_valid && write_ready in the same cycle: on the next edge write_valid=1, write_address=address register, write_data=byte, and the address register increments.
  - Data byte while write_valid && !write_ready: byte dropped, error_overflow=1, address not incremented.
  - WRITE persists until the next command byte. command_count increments when WRITE is exited by a command byte.
- FILL_RUN state:
  - Count=0: command_count+1, return to IDLE, no writes.
  - Otherwise issue count writes of colour at consecutive addresses, one per accepted handshake.
  - Back-to-back: with write_ready held at 1, throughput is 1 write per clock.
  - After the final acceptance: command_count+1, return to IDLE.
  - Data bytes during FILL_RUN are ignored.
- Address arithmetic: increment modulo 2^ADDRESS_WIDTH; (2^22-1)+1 = 0. No error on wrap.
- Handshake rules:
  - write_valid, write_address and write_data are held stable while write_valid && !write_ready.
  - write_valid drops the cycle after acceptance unless a new request is loaded in the same cycle.
- Latency: a data byte strobe appears as write_valid on the following clock edge (1 cycle).
- Sticky errors clear only on reset.

Test Plan:
- SET_ADDR 0x01,00,00,10, then WRITE 0x02,AA,BB, write_ready=1 -> writes (0x000010,AA) and (0x000011,BB), each 1 cycle after its strobe; command_count=1, becomes 2 after the next command byte.
- SET_ADDR to 0x3FFFFF, then FILL 0x03,55,00,00,03, write_ready=1 -> 3 consecutive-cycle writes to 0x3FFFFF, 0x000000, 0x000001, all value 55; return to IDLE; busy=0.
- WRITE with write_ready=0, bytes 11 and 22 -> request (addr,11) held stable; 22 dropped; error_overflow=1. Raise ready -> single write, address advanced by 1.
- Command 0x7E -> error_unknown=1, no write, command_count unchanged; a following NOP -> count+1.
- SET_ADDR 0x01,12 then 0x02 -> address unchanged; WRITE active; command_count unchanged by the aborted SET_ADDR.
- FILL count=0x000100 with reset pulsed low after 10 writes -> all outputs at reset values immediately (async); no further writes.
